// File: rtl/vga_timing_pkg.sv
// Package: vga_timing_pkg
// Shared types and default timing values for the VGA raster timing source.
// - coord_t          : 10-bit pixel/line coordinate
// - default 640x480@60 timing localparams
// - h_total/v_total  : helpers that sum the four segments of an axis
package vga_timing_pkg;

  typedef logic [9:0] coord_t;

  localparam int H_VISIBLE_DEF = 640;
  localparam int H_FRONT_DEF   = 16;
  localparam int H_SYNC_DEF    = 96;
  localparam int H_BACK_DEF    = 48;

  localparam int V_VISIBLE_DEF = 480;
  localparam int V_FRONT_DEF   = 10;
  localparam int V_SYNC_DEF    = 2;
  localparam int V_BACK_DEF    = 33;

  function automatic int h_total(input int vis, input int fp, input int sw, input int bp);
    return vis + fp + sw + bp;
  endfunction

  function automatic int v_total(input int vis, input int fp, input int sw, input int bp);
    return vis + fp + sw + bp;
  endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// Module: vga_axis_counter
// Wrap-at-TOTAL up counter for one raster axis.
// Ports:
//   clk  in   counting clock (rising edge)
//   rst  in   asynchronous active-high reset, clears the count
//   en   in   advance the count this cycle
//   cnt  out  current count, 0..TOTAL-1
//   tc   out  terminal count: en is high and cnt is TOTAL-1 (wraps this cycle)
module vga_axis_counter #(
  parameter int TOTAL = 800,
  parameter int W     = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  output logic [W-1:0] cnt,
  output logic         tc
);

  localparam logic [W-1:0] LAST = W'(TOTAL - 1);

  logic [W-1:0] cnt_q, cnt_d;

  assign tc = en && (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (en) cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/vga_timing_gen.sv
// Module: vga_timing_gen
// Free-running raster timing source (640x480@60 by default, 25 MHz vga_clk).
// Produces the pixel coordinate, visible-region flag and sync pulses consumed
// by the sprite/palette renderers.
// Ports:
//   vga_clk      in   pixel clock, all state on its rising edge
//   reset        in   asynchronous active-high reset
//   DrawX/DrawY  out  coordinate of the current pixel (counts through blanking)
//   blank        out  1 = visible pixel, renderers may drive colour
//   hs/vs        out  sync, level SYNC_POL while asserted
//   frame_start  out  one-cycle pulse with pixel (0,0)
//   frame_cnt    out  frames started since reset (only with VGA_FRAME_CNT_EN)
// Optional feature macro: VGA_FRAME_CNT_EN (adds frame_cnt port and counter).
// All outputs are registered from the current counter values, so they trail
// the internal counters by one clock and stay mutually aligned.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int H_VISIBLE   = H_VISIBLE_DEF,
  parameter int H_FRONT     = H_FRONT_DEF,
  parameter int H_SYNC      = H_SYNC_DEF,
  parameter int H_BACK      = H_BACK_DEF,
  parameter int V_VISIBLE   = V_VISIBLE_DEF,
  parameter int V_FRONT     = V_FRONT_DEF,
  parameter int V_SYNC      = V_SYNC_DEF,
  parameter int V_BACK      = V_BACK_DEF,
  parameter bit SYNC_POL    = 1'b0,
  parameter int FRAME_CNT_W = 8
) (
  input  logic                   vga_clk,
  input  logic                   reset,
  output logic [9:0]             DrawX,
  output logic [9:0]             DrawY,
  output logic                   blank,
  output logic                   hs,
  output logic                   vs,
  output logic                   frame_start
`ifdef VGA_FRAME_CNT_EN
  ,output logic [FRAME_CNT_W-1:0] frame_cnt
`endif
);

  localparam int H_TOTAL = h_total(H_VISIBLE, H_FRONT, H_SYNC, H_BACK);
  localparam int V_TOTAL = v_total(V_VISIBLE, V_FRONT, V_SYNC, V_BACK);

  localparam coord_t H_VIS_END  = coord_t'(H_VISIBLE);
  localparam coord_t H_SYNC_BEG = coord_t'(H_VISIBLE + H_FRONT);
  localparam coord_t H_SYNC_END = coord_t'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam coord_t V_VIS_END  = coord_t'(V_VISIBLE);
  localparam coord_t V_SYNC_BEG = coord_t'(V_VISIBLE + V_FRONT);
  localparam coord_t V_SYNC_END = coord_t'(V_VISIBLE + V_FRONT + V_SYNC);

  coord_t hc, vc;
  logic   h_tc;
  logic   v_tc_unused;

  vga_axis_counter #(.TOTAL(H_TOTAL), .W(10)) u_hcnt (
    .clk (vga_clk),
    .rst (reset),
    .en  (1'b1),
    .cnt (hc),
    .tc  (h_tc)
  );

  // Vertical axis advances only on the last pixel of each line.
  vga_axis_counter #(.TOTAL(V_TOTAL), .W(10)) u_vcnt (
    .clk (vga_clk),
    .rst (reset),
    .en  (h_tc),
    .cnt (vc),
    .tc  (v_tc_unused)
  );

  coord_t drawx_q, drawx_d;
  coord_t drawy_q, drawy_d;
  logic   blank_q, blank_d;
  logic   hs_q, hs_d;
  logic   vs_q, vs_d;
  logic   frame_start_q, frame_start_d;

  always_comb begin
    drawx_d       = hc;
    drawy_d       = vc;
    blank_d       = (hc < H_VIS_END) && (vc < V_VIS_END);
    hs_d          = ((hc >= H_SYNC_BEG) && (hc < H_SYNC_END)) ? SYNC_POL : ~SYNC_POL;
    // vs spans whole lines regardless of horizontal position.
    vs_d          = ((vc >= V_SYNC_BEG) && (vc < V_SYNC_END)) ? SYNC_POL : ~SYNC_POL;
    frame_start_d = (hc == '0) && (vc == '0);
  end

  always_ff @(posedge vga_clk or posedge reset) begin
    if (reset) begin
      drawx_q       <= '0;
      drawy_q       <= '0;
      blank_q       <= 1'b0;
      hs_q          <= ~SYNC_POL;
      vs_q          <= ~SYNC_POL;
      frame_start_q <= 1'b0;
    end else begin
      drawx_q       <= drawx_d;
      drawy_q       <= drawy_d;
      blank_q       <= blank_d;
      hs_q          <= hs_d;
      vs_q          <= vs_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign DrawX       = drawx_q;
  assign DrawY       = drawy_q;
  assign blank       = blank_q;
  assign hs          = hs_q;
  assign vs          = vs_q;
  assign frame_start = frame_start_q;

`ifdef VGA_FRAME_CNT_EN
  logic [FRAME_CNT_W-1:0] frame_cnt_q, frame_cnt_d;

  // Bumped alongside frame_start so the first frame after reset reads 1.
  always_comb begin
    frame_cnt_d = frame_cnt_q;
    if (frame_start_d) frame_cnt_d = frame_cnt_q + 1'b1;
  end

  always_ff @(posedge vga_clk or posedge reset) begin
    if (reset) frame_cnt_q <= '0;
    else       frame_cnt_q <= frame_cnt_d;
  end

  assign frame_cnt = frame_cnt_q;
`else
  localparam int FRAME_CNT_W_UNUSED = FRAME_CNT_W;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Testbench: tb_vga_timing_gen
// Two instances share clock and reset: one with default 640x480 timing (first
// lines checked) and one with a tiny raster and active-high sync so whole
// frames, wraps and frame counting are exercised in few cycles. Expected
// values come from the elapsed-clock count since reset release.
module tb_vga_timing_gen;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  // small raster: 28 x 17 = 476 clocks per frame
  localparam int SHV = 20, SHF = 2, SHS = 3, SHB = 3;
  localparam int SVV = 12, SVF = 1, SVS = 2, SVB = 2;

  logic [9:0] fx, fy, sx, sy;
  logic       fbl, fhs, fvs, ffs, sbl, shs, svs, sfs;
`ifdef VGA_FRAME_CNT_EN
  logic [7:0] ffc;
  logic [1:0] sfc;
`endif

  vga_timing_gen u_dut_full (
    .vga_clk(clk), .reset(reset), .DrawX(fx), .DrawY(fy), .blank(fbl),
    .hs(fhs), .vs(fvs), .frame_start(ffs)
`ifdef VGA_FRAME_CNT_EN
    , .frame_cnt(ffc)
`endif
  );

  vga_timing_gen #(
    .H_VISIBLE(SHV), .H_FRONT(SHF), .H_SYNC(SHS), .H_BACK(SHB),
    .V_VISIBLE(SVV), .V_FRONT(SVF), .V_SYNC(SVS), .V_BACK(SVB),
    .SYNC_POL(1'b1), .FRAME_CNT_W(2)
  ) u_dut_small (
    .vga_clk(clk), .reset(reset), .DrawX(sx), .DrawY(sy), .blank(sbl),
    .hs(shs), .vs(svs), .frame_start(sfs)
`ifdef VGA_FRAME_CNT_EN
    , .frame_cnt(sfc)
`endif
  );

  int nvec = 0;
  int nmis = 0;
  int k    = 0;  // rising edges since reset release

  task automatic chk(input string tag, input int obs, input int exp);
    nvec++;
    if (obs !== exp) begin
      nmis++;
      $display("FAIL %s k=%0d got %0d expected %0d", tag, k, obs, exp);
    end
  endtask

  typedef struct { int x, y, bl, hs, vs, fs, fc; } exp_t;

  // Raster position follows directly from elapsed clocks since release.
  function automatic exp_t model(input int kk, input int hv, input int hf, input int hsw,
                                 input int hb, input int vv, input int vf, input int vsw,
                                 input int vb, input int pol, input int fcw);
    exp_t e;
    int ht, vt, p;
    ht = hv + hf + hsw + hb;
    vt = vv + vf + vsw + vb;
    if (kk == 0) begin
      e = '{0, 0, 0, 1 - pol, 1 - pol, 0, 0};
    end else begin
      p    = (kk - 1) % (ht * vt);
      e.x  = p % ht;
      e.y  = p / ht;
      e.bl = (e.x < hv && e.y < vv) ? 1 : 0;
      e.hs = (e.x >= hv + hf && e.x < hv + hf + hsw) ? pol : 1 - pol;
      e.vs = (e.y >= vv + vf && e.y < vv + vf + vsw) ? pol : 1 - pol;
      e.fs = (p == 0) ? 1 : 0;
      e.fc = ((kk - 1) / (ht * vt) + 1) % (1 << fcw);
    end
    return e;
  endfunction

  task automatic check_all();
    exp_t ef, es;
    ef = model(k, 640, 16, 96, 48, 480, 10, 2, 33, 0, 8);
    es = model(k, SHV, SHF, SHS, SHB, SVV, SVF, SVS, SVB, 1, 2);
    chk("full.DrawX", int'(fx), ef.x);
    chk("full.DrawY", int'(fy), ef.y);
    chk("full.blank", int'(fbl), ef.bl);
    chk("full.hs", int'(fhs), ef.hs);
    chk("full.vs", int'(fvs), ef.vs);
    chk("full.frame_start", int'(ffs), ef.fs);
    chk("small.DrawX", int'(sx), es.x);
    chk("small.DrawY", int'(sy), es.y);
    chk("small.blank", int'(sbl), es.bl);
    chk("small.hs", int'(shs), es.hs);
    chk("small.vs", int'(svs), es.vs);
    chk("small.frame_start", int'(sfs), es.fs);
`ifdef VGA_FRAME_CNT_EN
    chk("full.frame_cnt", int'(ffc), ef.fc);
    chk("small.frame_cnt", int'(sfc), es.fc);
`endif
  endtask

  // One clock; outputs sampled on the falling edge.
  task automatic step();
    @(posedge clk);
    if (!reset) k++;
    @(negedge clk);
    check_all();
  endtask

  initial begin
    // reset held 5 clocks
    k = 0;
    repeat (5) step();
    reset = 1'b0;
    k = 0;
    // several lines of the default raster, ~6 frames of the small one
    repeat (3000) step();

    // random asynchronous resets landing mid-clock at random raster points
    for (int r = 0; r < 6; r++) begin
      repeat ($urandom_range(50, 1500)) step();
      #($urandom_range(1, 3));
      reset = 1'b1;
      k = 0;
      #1;
      check_all();
      repeat ($urandom_range(1, 3)) step();
      reset = 1'b0;
      k = 0;
      repeat ($urandom_range(2, 40)) step();
    end

    // a final clean run past several small-raster frame boundaries
    repeat (2500) step();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
